acc_requant_s10_20: RTL and testbench

- Output-side counterpart of the S5.10 MAC datapath. Consumes finished S10.20 accumulator beats and returns S5.10 activations for the next layer.
- Per beat: bias add, optional ReLU, round-to-nearest, saturate.
- 3-stage valid/ready pipeline with full backpressure and a saturation-event counter for quantisation monitoring.

---
 rtl/nn_fixed_pkg.sv | 15 +
 rtl/acc_requant_s10_20_if.sv | 29 ++
 rtl/pipe_stage_vr.sv | 32 +++
 rtl/acc_requant_s10_20.sv | 121 ++++++++++++
 tb/tb_acc_requant_s10_20.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_fixed_pkg.sv
// Fixed-point formats shared by the S5.10 MAC datapath and its requantiser.
// The S10.20 accumulator is the full-precision product sum of two S5.10 values.
package nn_fixed_pkg;

  localparam int FRAC_BITS = 10;
  localparam int ACC_W     = 32;
  localparam int OUT_W     = 16;

  typedef logic signed [15:0] s5_10_t;
  typedef logic signed [31:0] s10_20_t;

  localparam s5_10_t S5_10_MAX = 16'sh7FFF;
  localparam s5_10_t S5_10_MIN = 16'sh8000;

endpackage

// File: rtl/acc_requant_s10_20_if.sv
// Accumulator-in / activation-out streaming bundle of the requantiser.
// The slave modport is the requantiser side, the master modport is its environment.
interface acc_requant_s10_20_if #(
  parameter int ACC_W = nn_fixed_pkg::ACC_W,
  parameter int OUT_W = nn_fixed_pkg::OUT_W
);

  logic                    acc_valid;
  logic                    acc_ready;
  logic signed [ACC_W-1:0] acc_data;
  logic signed [OUT_W-1:0] bias;
  logic                    relu_en;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output acc_valid, acc_data, bias, relu_en, out_ready,
    input  acc_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  acc_valid, acc_data, bias, relu_en, out_ready,
    output acc_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/pipe_stage_vr.sv
// Generic valid/ready register slice: loads whenever empty or draining downstream,
// so a chain of these runs at one beat per cycle and stalls without bubbles.
module pipe_stage_vr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  assign up_ready = !dn_valid || dn_ready;

  // NOTE: sequential state uses non-blocking assignments so every slice samples
  // the pre-edge value of its neighbour, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      // NOTE: the payload is reset too, so the visible output reads 0 after reset
      // instead of stale data from a discarded beat.
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/acc_requant_s10_20.sv
// Requantises S10.20 accumulator beats to S5.10: bias add, optional ReLU,
// round half up, saturate; three register slices with full backpressure.
module acc_requant_s10_20 #(
  parameter int FRAC_BITS = nn_fixed_pkg::FRAC_BITS,
  parameter int ACC_W     = nn_fixed_pkg::ACC_W,
  parameter int OUT_W     = nn_fixed_pkg::OUT_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  acc_requant_s10_20_if.slave  bus,
  input  logic                 sat_clr,
  output logic [CNT_W-1:0]     sat_count
);

  localparam int S1_W = ACC_W + 1;
  localparam int R_W  = ACC_W + 2;
  localparam int P1_W = S1_W + 1;
  localparam int P3_W = OUT_W + 1;

  localparam logic signed [R_W-1:0] HALF  = R_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [R_W-1:0] R_MAX = R_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [R_W-1:0] R_MIN = ~R_MAX;
  localparam logic [OUT_W-1:0]      O_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]      O_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  logic                    in_ready;
  logic                    v1, v2, v3;
  logic                    rdy2, rdy3;
  logic [P1_W-1:0]         p1;
  logic [R_W-1:0]          p2;
  logic [P3_W-1:0]         p3;

  logic signed [S1_W-1:0]  s1_d;
  logic                    relu_q;
  logic signed [S1_W-1:0]  s1_q;
  logic signed [R_W-1:0]   s1_act;
  logic signed [R_W-1:0]   r_d;
  logic signed [R_W-1:0]   r_q;
  logic                    sat_d;
  logic [OUT_W-1:0]        out_d;

  // Bias is aligned to the accumulator's 2*FRAC_BITS fraction; one guard bit absorbs the carry.
  assign s1_d = $signed({bus.acc_data[ACC_W-1], bus.acc_data})
              + ($signed({{(S1_W - OUT_W){bus.bias[OUT_W-1]}}, bus.bias}) <<< FRAC_BITS);

  pipe_stage_vr #(.W(P1_W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (bus.acc_valid),
    .up_ready (in_ready),
    .up_data  ({bus.relu_en, s1_d}),
    .dn_valid (v1),
    .dn_ready (rdy2),
    .dn_data  (p1)
  );

  assign relu_q = p1[P1_W-1];
  assign s1_q   = p1[S1_W-1:0];

  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    s1_act = {s1_q[S1_W-1], s1_q};
    if (relu_q && s1_q[S1_W-1]) s1_act = '0;
    r_d = (s1_act + HALF) >>> FRAC_BITS;
  end

  pipe_stage_vr #(.W(R_W)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (v1),
    .up_ready (rdy2),
    .up_data  (r_d),
    .dn_valid (v2),
    .dn_ready (rdy3),
    .dn_data  (p2)
  );

  assign r_q = p2;

  always_comb begin
    sat_d = 1'b0;
    out_d = r_q[OUT_W-1:0];
    if (r_q > R_MAX) begin
      sat_d = 1'b1;
      out_d = O_MAX;
    end else if (r_q < R_MIN) begin
      sat_d = 1'b1;
      out_d = O_MIN;
    end
  end

  pipe_stage_vr #(.W(P3_W)) u_s3 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (v2),
    .up_ready (rdy3),
    .up_data  ({sat_d, out_d}),
    .dn_valid (v3),
    .dn_ready (bus.out_ready),
    .dn_data  (p3)
  );

  assign bus.acc_ready = in_ready;
  assign bus.out_valid = v3;
  assign bus.out_sat   = p3[OUT_W];
  assign bus.out_data  = p3[OUT_W-1:0];

  // Counts delivered clamped beats only; sticky at all-ones, clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (v3 && bus.out_ready && p3[OUT_W] && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_acc_requant_s10_20.sv
// Self-checking bench for acc_requant_s10_20: directed corner beats plus randomized
// streams scored against an integer-arithmetic reference model.
module tb_acc_requant_s10_20;
  import nn_fixed_pkg::*;

  typedef struct packed {
    logic   sat;
    s5_10_t data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;

  int n_pass  = 0;
  int n_total = 0;

  acc_requant_s10_20_if bus ();

  acc_requant_s10_20 dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic straight from the format definitions.
  function automatic res_t ref_model(input s10_20_t acc, input s5_10_t b, input logic relu);
    longint s, r;
    res_t   o;
    s = longint'(acc) + longint'(b) * (longint'(1) << FRAC_BITS);
    if (relu && s < 0) s = 0;
    r = (s + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
    if (r > 32767) begin
      o.sat = 1'b1; o.data = S5_10_MAX;
    end else if (r < -32768) begin
      o.sat = 1'b1; o.data = S5_10_MIN;
    end else begin
      o.sat = 1'b0; o.data = s5_10_t'(r);
    end
    return o;
  endfunction

  // Sends one beat with out_ready high; returns the result and cycles from accept to out_valid.
  task automatic send_one(input s10_20_t acc, input s5_10_t b, input logic relu,
                          output s5_10_t d, output logic s, output int lat);
    int guard;
    @(negedge clk);
    bus.acc_valid = 1'b1; bus.acc_data = acc; bus.bias = b; bus.relu_en = relu;
    bus.out_ready = 1'b1;
    guard = 0;
    #1;
    while (!bus.acc_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    @(negedge clk);
    bus.acc_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    d = bus.out_data;
    s = bus.out_sat;
  endtask

  task automatic pulse_clr();
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_sat !== 1'b0) begin
      $display("FAIL reset_outputs: got valid=%b data=%0d sat=%b, want 0/0/0",
               bus.out_valid, bus.out_data, bus.out_sat);
    end else n_pass++;
    n_total++;
    if (sat_count !== 16'd0) $display("FAIL reset_sat_count: got %0d want 0", sat_count);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    #1;
    n_total++;
    if (bus.acc_ready !== 1'b1) $display("FAIL reset_acc_ready: got %b want 1", bus.acc_ready);
    else n_pass++;
  endtask

  task automatic test_rounding();
    s10_20_t acc_t [4] = '{32'sd1536, -32'sd1536, 32'sd511, 32'sd512};
    s5_10_t  exp_t [4] = '{16'sd2, -16'sd1, 16'sd0, 16'sd1};
    s5_10_t  d;
    logic    s;
    int      lat;
    for (int i = 0; i < 4; i++) begin
      send_one(acc_t[i], 16'sd0, 1'b0, d, s, lat);
      n_total++;
      if (d !== exp_t[i]) $display("FAIL round_data[%0d]: got %0d want %0d", i, d, exp_t[i]);
      else n_pass++;
      n_total++;
      if (s !== 1'b0) $display("FAIL round_sat[%0d]: got %b want 0", i, s);
      else n_pass++;
      n_total++;
      if (lat !== 3) $display("FAIL round_latency[%0d]: got %0d want 3", i, lat);
      else n_pass++;
    end
  endtask

  task automatic test_bias_relu();
    s5_10_t d;
    logic   s;
    int     lat;
    send_one(32'sh0010_0000, 16'shF800, 1'b0, d, s, lat);
    n_total++;
    if (d !== 16'shFC00 || s !== 1'b0)
      $display("FAIL bias_add: got data=%0d sat=%b want -1024/0", d, s);
    else n_pass++;
    send_one(32'sh0010_0000, 16'shF800, 1'b1, d, s, lat);
    n_total++;
    if (d !== 16'sd0 || s !== 1'b0)
      $display("FAIL relu: got data=%0d sat=%b want 0/0", d, s);
    else n_pass++;
  endtask

  task automatic test_saturation();
    s5_10_t d;
    logic   s;
    int     lat;
    pulse_clr();
    send_one(32'sh7FFF_FFFF, 16'sd0, 1'b0, d, s, lat);
    n_total++;
    if (d !== 16'sd32767 || s !== 1'b1)
      $display("FAIL sat_high: got data=%0d sat=%b want 32767/1", d, s);
    else n_pass++;
    send_one(32'sh8000_0000, 16'sd0, 1'b0, d, s, lat);
    n_total++;
    if (d !== -16'sd32768 || s !== 1'b1)
      $display("FAIL sat_low: got data=%0d sat=%b want -32768/1", d, s);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (sat_count !== 16'd2) $display("FAIL sat_count_two: got %0d want 2", sat_count);
    else n_pass++;
  endtask

  task automatic test_sat_hold();
    int     sent = 0, got = 0, cyc = 0;
    s5_10_t d;
    logic   s;
    int     lat;
    pulse_clr();
    bus.acc_data = 32'sh7FFF_FFFF; bus.bias = 16'sd0; bus.relu_en = 1'b0; bus.out_ready = 1'b1;
    while (got < 65539 && cyc < 70000) begin
      @(negedge clk); cyc++;
      bus.acc_valid = (sent < 65539);
      #1;
      if (bus.out_valid && bus.out_ready) got++;
      if (bus.acc_valid && bus.acc_ready) sent++;
    end
    @(negedge clk); bus.acc_valid = 1'b0;
    n_total++;
    if (got !== 65539) $display("FAIL sat_hold_beats: got %0d want 65539", got);
    else n_pass++;
    n_total++;
    if (sat_count !== 16'hFFFF) $display("FAIL sat_hold_max: got %0d want 65535", sat_count);
    else n_pass++;
    // Clear on the very cycle of a counted handshake.
    send_one(32'sh7FFF_FFFF, 16'sd0, 1'b0, d, s, lat);
    sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    n_total++;
    if (sat_count !== 16'd0) $display("FAIL sat_clr_wins: got %0d want 0", sat_count);
    else n_pass++;
    send_one(32'sh8000_0000, 16'sd0, 1'b0, d, s, lat);
    @(negedge clk);
    n_total++;
    if (sat_count !== 16'd1) $display("FAIL sat_count_after_clr: got %0d want 1", sat_count);
    else n_pass++;
  endtask

  // mode 0: random out_ready; mode 1: out_ready low for 5 cycles mid-stream.
  task automatic run_stream(input int n, input int mode, output int sat_seen, output logic saw_drop);
    res_t    exp_q [$];
    res_t    e;
    s10_20_t acc;
    s5_10_t  b;
    logic    relu;
    logic    have = 1'b0, prev_stall = 1'b0, prev_s = 1'b0;
    s5_10_t  prev_d = '0;
    int      sent = 0, recv = 0, cyc = 0;
    sat_seen = 0;
    saw_drop = 1'b0;
    while (recv < n && cyc < n * 6 + 100) begin
      @(negedge clk); cyc++;
      if (prev_stall) begin
        n_total++;
        if (bus.out_data !== prev_d || bus.out_sat !== prev_s)
          $display("FAIL stall_stable: got %0d/%b want %0d/%b", bus.out_data, bus.out_sat, prev_d, prev_s);
        else n_pass++;
      end
      bus.out_ready = (mode == 1) ? !(cyc >= 8 && cyc < 13) : 1'($urandom_range(0, 1));
      if (!have && sent < n) begin
        acc  = $urandom_range(0, 1) ? s10_20_t'($urandom)
                                    : s10_20_t'(int'($urandom_range(0, 1 << 26)) - (1 << 25));
        b    = s5_10_t'($urandom);
        relu = 1'($urandom_range(0, 1));
        bus.acc_data = acc; bus.bias = b; bus.relu_en = relu;
        have = 1'b1;
      end
      bus.acc_valid = have;
      #1;
      if (mode == 1 && !bus.acc_ready) saw_drop = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra_beat: got %0d with nothing expected", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e.data || bus.out_sat !== e.sat)
            $display("FAIL stream_beat[%0d]: got %0d/%b want %0d/%b", recv, bus.out_data, bus.out_sat, e.data, e.sat);
          else n_pass++;
          if (e.sat) sat_seen++;
        end
        recv++;
      end
      if (bus.acc_valid && bus.acc_ready) begin
        exp_q.push_back(ref_model(acc, b, relu));
        sent++;
        have = 1'b0;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d     = bus.out_data;
      prev_s     = bus.out_sat;
    end
    n_total++;
    if (recv !== n || exp_q.size() != 0)
      $display("FAIL stream_count: got %0d beats (%0d pending) want %0d", recv, exp_q.size(), n);
    else n_pass++;
    @(negedge clk);
    bus.acc_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   sats;
    logic drop;
    run_stream(20, 1, sats, drop);
    n_total++;
    if (drop !== 1'b1) $display("FAIL backpressure_ready_drop: got %b want 1", drop);
    else n_pass++;
  endtask

  task automatic test_random();
    int   sats;
    logic drop;
    pulse_clr();
    run_stream(10000, 0, sats, drop);
    n_total++;
    if (sat_count !== 16'(sats)) $display("FAIL random_sat_count: got %0d want %0d", sat_count, sats);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    s5_10_t d;
    logic   s;
    int     lat;
    int     stale = 0;
    send_one(32'sh7FFF_FFFF, 16'sd0, 1'b0, d, s, lat);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.acc_valid = 1'b1; bus.acc_data = s10_20_t'((i + 1) * 1024); bus.bias = 16'sd0; bus.relu_en = 1'b0;
      @(negedge clk);
    end
    bus.acc_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b1 || sat_count === 16'd0)
      $display("FAIL inflight_setup: got valid=%b count=%0d want 1/nonzero", bus.out_valid, sat_count);
    else n_pass++;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 || bus.out_sat !== 1'b0 || sat_count !== 16'd0)
      $display("FAIL async_reset: got valid=%b data=%0d sat=%b count=%0d want all 0",
               bus.out_valid, bus.out_data, bus.out_sat, sat_count);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    send_one(32'sd5120, 16'sd0, 1'b0, d, s, lat);
    n_total++;
    if (d !== 16'sd5 || s !== 1'b0 || lat !== 3)
      $display("FAIL post_reset_beat: got data=%0d sat=%b lat=%0d want 5/0/3", d, s, lat);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    n_total++;
    if (stale !== 0) $display("FAIL stale_beats: got %0d want 0", stale);
    else n_pass++;
  endtask

  initial begin
    bus.acc_valid = 1'b0; bus.acc_data = '0; bus.bias = '0; bus.relu_en = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_rounding();
    test_bias_relu();
    test_saturation();
    test_back_to_back();
    test_random();
    test_sat_hold();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
